// File: rtl/pol_ofm_wb_pkg.sv
// rtl/pol_ofm_wb_pkg.sv - shared state encoding, beat constants and ceil-div helper for the pooling write-back stage
package pol_ofm_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  localparam int unsigned DEF_ACT_WIDTH      = 8;
  localparam int unsigned DEF_POOL_COMP_CORE = 64;
  localparam int unsigned DEF_SRAM_WIDTH     = 256;

  // GLB words per pooled point and channels per GLB word for the default geometry
  localparam int unsigned RATIO = DEF_ACT_WIDTH * DEF_POOL_COMP_CORE / DEF_SRAM_WIDTH;
  localparam int unsigned CPW   = DEF_SRAM_WIDTH / DEF_ACT_WIDTH;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/pol_wb_slicer.sv
// rtl/pol_wb_slicer.sv - combinational beat select of the buffered point with masking of channels >= Chi
module pol_wb_slicer
  import pol_ofm_wb_pkg::*;
#(
  parameter int ACT_WIDTH      = 8,
  parameter int POOL_COMP_CORE = 64,
  parameter int SRAM_WIDTH     = 256,
  parameter int CHN_WIDTH      = 12,
  parameter int BW             = 1,
  parameter int PW             = ACT_WIDTH * POOL_COMP_CORE
) (
  input  logic [PW-1:0]         buf_i,
  input  logic [BW-1:0]         beat_i,
  input  logic [CHN_WIDTH-1:0]  chi_i,
  output logic [SRAM_WIDTH-1:0] dat_o
);

  localparam int NBEAT  = PW / SRAM_WIDTH;
  localparam int CPW_L  = SRAM_WIDTH / ACT_WIDTH;

  logic [SRAM_WIDTH-1:0] word;
  logic [CHN_WIDTH-1:0]  chan;

  // pick the current beat, then zero every channel at or beyond the valid channel count
  always_comb begin
    word  = '0;
    dat_o = '0;
    chan  = '0;
    for (int k = 0; k < NBEAT; k++) begin
      if (beat_i == BW'(k)) word = buf_i[k*SRAM_WIDTH +: SRAM_WIDTH];
    end
    for (int j = 0; j < CPW_L; j++) begin
      chan = CHN_WIDTH'(beat_i) * CHN_WIDTH'(CPW_L) + CHN_WIDTH'(j);
      if (chan < chi_i) dat_o[j*ACT_WIDTH +: ACT_WIDTH] = word[j*ACT_WIDTH +: ACT_WIDTH];
    end
  end

endmodule

// File: rtl/pol_ofm_wb.sv
// rtl/pol_ofm_wb.sv - pooled-point write-back to GLB; optional checksum output under POL_WB_CHKSUM_EN
module pol_ofm_wb
  import pol_ofm_wb_pkg::*;
#(
  parameter int ACT_WIDTH      = DEF_ACT_WIDTH,
  parameter int POOL_COMP_CORE = DEF_POOL_COMP_CORE,
  parameter int IDX_WIDTH      = 10,
  parameter int CHN_WIDTH      = 12,
  parameter int SRAM_WIDTH     = DEF_SRAM_WIDTH,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                CCUWB_Rst,
  input  logic                                CCUWB_CfgVld,
  output logic                                WBCCU_CfgRdy,
  input  logic [IDX_WIDTH-1:0]                CCUWB_CfgNop,
  input  logic [CHN_WIDTH-1:0]                CCUWB_CfgChi,
  input  logic [ADDR_WIDTH-1:0]               CCUWB_CfgAddr,
  output logic                                WBCCU_Done,
`ifdef POL_WB_CHKSUM_EN
  output logic [SRAM_WIDTH-1:0]               WBCCU_Chksum,
`endif
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLWB_Ofm,
  input  logic                                POLWB_OfmVld,
  output logic                                WBPOL_OfmRdy,
  output logic [SRAM_WIDTH-1:0]               WBGLB_Dat,
  output logic [ADDR_WIDTH-1:0]               WBGLB_Addr,
  output logic                                WBGLB_DatVld,
  input  logic                                GLBWB_DatRdy
);

  localparam int PW    = ACT_WIDTH * POOL_COMP_CORE;
  localparam int NBEAT = PW / SRAM_WIDTH;
  localparam int CPW_L = SRAM_WIDTH / ACT_WIDTH;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  wb_state_e state_q, state_d;

  logic [IDX_WIDTH-1:0]  nop_q, pnt_cnt_q;
  logic [CHN_WIDTH-1:0]  chi_q;
  logic [ADDR_WIDTH-1:0] base_q, wr_cnt_q;
  logic [BW:0]           nb_q;
  logic [BW-1:0]         beat_q;
  logic [PW-1:0]         buf_q;
  logic                  full_q;

  logic [CHN_WIDTH-1:0]  chi_eff;
  logic [BW:0]           nb_cfg;
  logic                  cfg_fire, wr_fire, last_beat, pnt_fin, room, ofm_rdy, ofm_fire;

  // out-of-range channel counts mean a full point
  assign chi_eff = (CCUWB_CfgChi == '0 || CCUWB_CfgChi > CHN_WIDTH'(POOL_COMP_CORE))
                   ? CHN_WIDTH'(POOL_COMP_CORE) : CCUWB_CfgChi;
  assign nb_cfg  = (BW+1)'(ceil_div(32'(chi_eff), 32'(CPW_L)));

  assign cfg_fire  = (state_q == ST_IDLE) & CCUWB_CfgVld;
  assign wr_fire   = (state_q == ST_RUN) & full_q & GLBWB_DatRdy;
  assign last_beat = ({1'b0, beat_q} == nb_q - (BW+1)'(1));
  assign pnt_fin   = wr_fire & last_beat;
  // the buffered point already counts toward Nop, so no extra point slips in behind the last one
  assign room      = ((IDX_WIDTH+1)'(pnt_cnt_q) + (IDX_WIDTH+1)'(full_q)) < {1'b0, nop_q};
  assign ofm_rdy   = (state_q == ST_RUN) & room & (~full_q | pnt_fin);
  assign ofm_fire  = ofm_rdy & POLWB_OfmVld;

  assign WBPOL_OfmRdy = ofm_rdy;
  assign WBCCU_CfgRdy = (state_q == ST_IDLE);
  assign WBCCU_Done   = (state_q == ST_DONE);
  assign WBGLB_DatVld = full_q;
  assign WBGLB_Addr   = base_q + wr_cnt_q;

  pol_wb_slicer #(
    .ACT_WIDTH      (ACT_WIDTH),
    .POOL_COMP_CORE (POOL_COMP_CORE),
    .SRAM_WIDTH     (SRAM_WIDTH),
    .CHN_WIDTH      (CHN_WIDTH),
    .BW             (BW)
  ) u_slicer (
    .buf_i  (buf_q),
    .beat_i (beat_q),
    .chi_i  (chi_q),
    .dat_o  (WBGLB_Dat)
  );

  // job sequencing: config -> stream points until all written -> one-cycle done
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (CCUWB_CfgVld) state_d = ST_RUN;
      ST_RUN:  if (pnt_cnt_q == nop_q && !full_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state register with soft reset back to idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            state_q <= ST_IDLE;
    else if (CCUWB_Rst) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // config latch, point buffer, beat/write/point counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nop_q     <= '0;
      chi_q     <= '0;
      base_q    <= '0;
      nb_q      <= '0;
      pnt_cnt_q <= '0;
      wr_cnt_q  <= '0;
      beat_q    <= '0;
      buf_q     <= '0;
      full_q    <= 1'b0;
    end else if (CCUWB_Rst) begin
      nop_q     <= '0;
      chi_q     <= '0;
      base_q    <= '0;
      nb_q      <= '0;
      pnt_cnt_q <= '0;
      wr_cnt_q  <= '0;
      beat_q    <= '0;
      buf_q     <= '0;
      full_q    <= 1'b0;
    end else begin
      if (cfg_fire) begin
        nop_q     <= CCUWB_CfgNop;
        chi_q     <= chi_eff;
        base_q    <= CCUWB_CfgAddr;
        nb_q      <= nb_cfg;
        pnt_cnt_q <= '0;
        wr_cnt_q  <= '0;
      end
      if (wr_fire) begin
        wr_cnt_q <= wr_cnt_q + ADDR_WIDTH'(1);
        if (last_beat) begin
          beat_q    <= '0;
          pnt_cnt_q <= pnt_cnt_q + IDX_WIDTH'(1);
        end else begin
          beat_q <= beat_q + BW'(1);
        end
      end
      if (ofm_fire) begin
        buf_q  <= POLWB_Ofm;
        full_q <= 1'b1;
        beat_q <= '0;
      end else if (pnt_fin) begin
        full_q <= 1'b0;
      end
    end
  end

`ifdef POL_WB_CHKSUM_EN
  logic [SRAM_WIDTH-1:0] chk_q;

  // running XOR of every word handed to the GLB during the current job
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            chk_q <= '0;
    else if (CCUWB_Rst) chk_q <= '0;
    else if (cfg_fire)  chk_q <= '0;
    else if (wr_fire)   chk_q <= chk_q ^ WBGLB_Dat;
  end

  assign WBCCU_Chksum = chk_q;
`endif

endmodule

// File: tb/tb_pol_ofm_wb.sv
// tb/tb_pol_ofm_wb.sv - directed self-checking bench for pol_ofm_wb
module tb_pol_ofm_wb;

  localparam int PW = 512;
  localparam int SW = 256;
  localparam int AW = 16;
  localparam int IW = 10;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          soft_rst = 1'b0;
  logic          cfg_vld = 1'b0;
  logic          cfg_rdy;
  logic [IW-1:0] cfg_nop = '0;
  logic [CW-1:0] cfg_chi = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic          done;
  logic [PW-1:0] ofm = '0;
  logic          ofm_vld = 1'b0;
  logic          ofm_rdy;
  logic [SW-1:0] dat;
  logic [AW-1:0] waddr;
  logic          dat_vld;
  logic          glb_rdy = 1'b0;
`ifdef POL_WB_CHKSUM_EN
  logic [SW-1:0] chksum;
`endif

  pol_ofm_wb dut (
    .clk           (clk),
    .rst           (rst),
    .CCUWB_Rst     (soft_rst),
    .CCUWB_CfgVld  (cfg_vld),
    .WBCCU_CfgRdy  (cfg_rdy),
    .CCUWB_CfgNop  (cfg_nop),
    .CCUWB_CfgChi  (cfg_chi),
    .CCUWB_CfgAddr (cfg_addr),
    .WBCCU_Done    (done),
`ifdef POL_WB_CHKSUM_EN
    .WBCCU_Chksum  (chksum),
`endif
    .POLWB_Ofm     (ofm),
    .POLWB_OfmVld  (ofm_vld),
    .WBPOL_OfmRdy  (ofm_rdy),
    .WBGLB_Dat     (dat),
    .WBGLB_Addr    (waddr),
    .WBGLB_DatVld  (dat_vld),
    .GLBWB_DatRdy  (glb_rdy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [SW-1:0] wq_dat[$];
  int            wq_addr[$];
  int            wq_cyc[$];
  int            done_cnt, done_cyc, sent, stall_err;
  int            job_seed = 0;

  function automatic logic [PW-1:0] mk_point(input int p);
    logic [PW-1:0] v;
    v = '0;
    for (int c = 0; c < 64; c++) v[c*8 +: 8] = 8'(job_seed * 37 + p * 16 + c + 1);
    return v;
  endfunction

  function automatic logic [SW-1:0] exp_beat(input int p, input int k, input int chi);
    logic [PW-1:0] pt;
    logic [SW-1:0] w;
    pt = mk_point(p);
    w  = '0;
    for (int j = 0; j < 32; j++) begin
      if (k * 32 + j < chi) w[j*8 +: 8] = pt[(k*32+j)*8 +: 8];
    end
    return w;
  endfunction

  task automatic run_job(input int nop, input int chi, input int addr, input int rdy_pct, input int max_cyc);
    logic [SW-1:0] pdat;
    logic [AW-1:0] paddr;
    bit            phold;
    wq_dat.delete(); wq_addr.delete(); wq_cyc.delete();
    done_cnt = 0; done_cyc = -1; sent = 0; stall_err = 0; phold = 0;
    pdat = '0; paddr = '0;
    @(negedge clk);
    cfg_vld = 1'b1; cfg_nop = IW'(nop); cfg_chi = CW'(chi); cfg_addr = AW'(addr);
    @(negedge clk);
    cfg_vld = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (phold && (dat_vld !== 1'b1 || dat !== pdat || waddr !== paddr)) stall_err++;
      glb_rdy = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
      ofm     = mk_point(sent);
      ofm_vld = (sent <= nop);
      #1;
      if (dat_vld === 1'b1 && glb_rdy) begin
        wq_dat.push_back(dat);
        wq_addr.push_back(int'(waddr));
        wq_cyc.push_back(cyc);
      end
      phold = (dat_vld === 1'b1) && !glb_rdy;
      pdat  = dat;
      paddr = waddr;
      if (ofm_vld && ofm_rdy === 1'b1) sent++;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    ofm_vld = 1'b0;
    glb_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL reset_cfg_rdy got=%b want=1", cfg_rdy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (ofm_rdy !== 1'b0) begin bad++; $display("FAIL reset_ofm_rdy got=%b want=0", ofm_rdy); end
    total++; if (dat_vld !== 1'b0) begin bad++; $display("FAIL reset_dat_vld got=%b want=0", dat_vld); end
    total++; if (waddr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", waddr); end
    total++; if (dat !== '0) begin bad++; $display("FAIL reset_dat got=%h want=0", dat); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [SW-1:0] x;
    job_seed = 1;
    run_job(3, 64, 'h0100, 100, 300);
    x = '0;
    total++; if (wq_dat.size() != 6) begin bad++; $display("FAIL basic_nwrites got=%0d want=6", wq_dat.size()); end
    for (int i = 0; i < 6; i++) begin
      x = x ^ exp_beat(i / 2, i % 2, 64);
      total++;
      if (i >= wq_dat.size()) begin bad++; $display("FAIL basic_missing_write idx=%0d", i); end
      else begin
        if (wq_addr[i] != 'h100 + i) begin bad++; $display("FAIL basic_addr idx=%0d got=%h want=%h", i, wq_addr[i], 'h100 + i); end
        else if (wq_dat[i] !== exp_beat(i / 2, i % 2, 64)) begin bad++; $display("FAIL basic_dat idx=%0d got=%h want=%h", i, wq_dat[i], exp_beat(i / 2, i % 2, 64)); end
      end
    end
    total++; if (wq_cyc.size() == 6 && (wq_cyc[0] != 1 || wq_cyc[5] != 6)) begin bad++; $display("FAIL basic_b2b first=%0d last=%0d want=1,6", wq_cyc[0], wq_cyc[5]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt); end
    total++; if (done_cyc != 8) begin bad++; $display("FAIL basic_done_cyc got=%0d want=8", done_cyc); end
    total++; if (sent != 3) begin bad++; $display("FAIL basic_points_accepted got=%0d want=3", sent); end
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL basic_idle_after got=%b want=1", cfg_rdy); end
`ifdef POL_WB_CHKSUM_EN
    total++; if (chksum !== x) begin bad++; $display("FAIL basic_chksum got=%h want=%h", chksum, x); end
`endif
  endtask

  task automatic test_chi20();
    job_seed = 2;
    run_job(2, 20, 'h0200, 100, 200);
    total++; if (wq_dat.size() != 2) begin bad++; $display("FAIL chi20_nwrites got=%0d want=2", wq_dat.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= wq_dat.size()) begin bad++; $display("FAIL chi20_missing_write idx=%0d", i); end
      else begin
        if (wq_addr[i] != 'h200 + i) begin bad++; $display("FAIL chi20_addr idx=%0d got=%h want=%h", i, wq_addr[i], 'h200 + i); end
        else if (wq_dat[i] !== exp_beat(i, 0, 20)) begin bad++; $display("FAIL chi20_dat idx=%0d got=%h want=%h", i, wq_dat[i], exp_beat(i, 0, 20)); end
        else if (wq_dat[i][255:160] !== '0) begin bad++; $display("FAIL chi20_mask idx=%0d got=%h want=0", i, wq_dat[i][255:160]); end
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL chi20_done_cnt got=%0d want=1", done_cnt); end
  endtask

  task automatic test_chi_zero();
    job_seed = 3;
    run_job(1, 0, 'h0500, 100, 100);
    total++; if (wq_dat.size() != 2) begin bad++; $display("FAIL chi0_nwrites got=%0d want=2", wq_dat.size()); end
    else begin
      total++; if (wq_dat[1] !== exp_beat(0, 1, 64)) begin bad++; $display("FAIL chi0_dat1 got=%h want=%h", wq_dat[1], exp_beat(0, 1, 64)); end
    end
  endtask

  task automatic test_stall();
    job_seed = 4;
    run_job(4, 64, 'h0300, 50, 2000);
    total++; if (wq_dat.size() != 8) begin bad++; $display("FAIL stall_nwrites got=%0d want=8", wq_dat.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= wq_dat.size()) begin bad++; $display("FAIL stall_missing_write idx=%0d", i); end
      else if (wq_addr[i] != 'h300 + i || wq_dat[i] !== exp_beat(i / 2, i % 2, 64)) begin
        bad++; $display("FAIL stall_write idx=%0d addr=%h want_addr=%h dat=%h want=%h", i, wq_addr[i], 'h300 + i, wq_dat[i], exp_beat(i / 2, i % 2, 64));
      end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", stall_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done_cnt got=%0d want=1", done_cnt); end
  endtask

  task automatic test_wrap();
    int exp_a[4];
    exp_a = '{'hFFFF, 'h0000, 'h0001, 'h0002};
    job_seed = 5;
    run_job(2, 64, 'hFFFF, 100, 200);
    total++; if (wq_addr.size() != 4) begin bad++; $display("FAIL wrap_nwrites got=%0d want=4", wq_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= wq_addr.size()) begin bad++; $display("FAIL wrap_missing_write idx=%0d", i); end
      else if (wq_addr[i] != exp_a[i]) begin bad++; $display("FAIL wrap_addr idx=%0d got=%h want=%h", i, wq_addr[i], exp_a[i]); end
    end
  endtask

  task automatic test_soft_reset();
    int dn;
    job_seed = 6;
    @(negedge clk);
    cfg_vld = 1'b1; cfg_nop = IW'(3); cfg_chi = CW'(64); cfg_addr = AW'('h20);
    @(negedge clk);
    cfg_vld = 1'b0; glb_rdy = 1'b0; ofm = mk_point(0); ofm_vld = 1'b1;
    @(negedge clk);
    ofm_vld = 1'b0;
    total++; if (dat_vld !== 1'b1) begin bad++; $display("FAIL srst_buffered got=%b want=1", dat_vld); end
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL srst_cfg_rdy got=%b want=1", cfg_rdy); end
    total++; if (dat_vld !== 1'b0) begin bad++; $display("FAIL srst_dat_vld got=%b want=0", dat_vld); end
    total++; if (ofm_rdy !== 1'b0) begin bad++; $display("FAIL srst_ofm_rdy got=%b want=0", ofm_rdy); end
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    total++; if (dn != 0) begin bad++; $display("FAIL srst_no_done got=%0d want=0", dn); end
    run_job(1, 64, 'h0040, 100, 100);
    total++; if (wq_dat.size() != 2) begin bad++; $display("FAIL srst_next_nwrites got=%0d want=2", wq_dat.size()); end
    else begin
      total++; if (wq_addr[0] != 'h40 || wq_addr[1] != 'h41) begin bad++; $display("FAIL srst_next_addr got=%h,%h want=40,41", wq_addr[0], wq_addr[1]); end
      total++; if (wq_dat[0] !== exp_beat(0, 0, 64)) begin bad++; $display("FAIL srst_next_dat got=%h want=%h", wq_dat[0], exp_beat(0, 0, 64)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL srst_next_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_nop0();
    job_seed = 7;
    run_job(0, 64, 'h0600, 100, 50);
    total++; if (wq_dat.size() != 0) begin bad++; $display("FAIL nop0_nwrites got=%0d want=0", wq_dat.size()); end
    total++; if (done_cyc != 1) begin bad++; $display("FAIL nop0_done_cyc got=%0d want=1", done_cyc); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL nop0_done_cnt got=%0d want=1", done_cnt); end
    total++; if (sent != 0) begin bad++; $display("FAIL nop0_points got=%0d want=0", sent); end
`ifdef POL_WB_CHKSUM_EN
    total++; if (chksum !== '0) begin bad++; $display("FAIL nop0_chksum got=%h want=0", chksum); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chi20();
    test_chi_zero();
    test_stall();
    test_wrap();
    test_soft_reset();
    test_nop0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
